// File: rtl/scan_bridge_pkg.sv
// Shared types and constants for the scan bridge: FSM state encoding,
// scan chain length and the default processor-run limit.
package scan_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int unsigned SHIFT_BITS        = 8;
    localparam int unsigned RUN_LIMIT_DEFAULT = 4096;

endpackage

// File: rtl/scan_bridge.sv
// Byte-wide bridge to a core's serial scan chain, plus run-until-halt control.
// Optional run watchdog: define SCAN_BRIDGE_WATCHDOG_EN.
module scan_bridge
    import scan_bridge_pkg::*;
#(
    parameter int unsigned RUN_LIMIT = RUN_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    input  logic       run_req,
    output logic       busy,
    output logic       timeout,
    output logic       scan_enable,
    output logic       scan_in,
    output logic       proc_en,
    input  logic       scan_out,
    input  logic       halt
);

    localparam int unsigned CNT_W = $clog2(SHIFT_BITS);

    state_t                state, state_nxt;
    logic [SHIFT_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  wr_xfer;
    logic                  rd_xfer;
    logic                  run_go;
    logic                  run_expire;

    assign wr_xfer = wr_valid && wr_ready;
    assign rd_xfer = rd_valid && rd_ready;
    // A coincident write takes priority; the run request is dropped, not queued.
    assign run_go  = (state == IDLE) && run_req && !wr_xfer;

`ifdef SCAN_BRIDGE_WATCHDOG_EN
    localparam int unsigned RUN_W = $clog2(RUN_LIMIT + 1);

    logic [RUN_W-1:0] run_cnt;
    logic             timeout_q;

    // Halt seen on the same edge as expiry ends the run cleanly, without timeout.
    assign run_expire = (state == RUN) && !halt && (run_cnt == RUN_W'(RUN_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (run_go) begin
            run_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (state == RUN) begin
            run_cnt <= run_cnt + RUN_W'(1);
            if (run_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign run_expire = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_xfer) begin
                    state_nxt = SHIFT;
                end else if (run_go) begin
                    state_nxt = RUN;
                end
            end
            SHIFT: begin
                if (bit_cnt == CNT_W'(SHIFT_BITS - 1)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (rd_xfer) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (halt || run_expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The shift register doubles as the capture register: after the eighth
    // shift it holds the byte that came out of the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_xfer) begin
                        shreg <= wr_data;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[SHIFT_BITS-2:0], scan_out};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rd_valid    = (state == HOLD);
    assign rd_data     = rd_valid ? shreg : '0;
    assign wr_ready    = rst_n && (state == IDLE) && !rd_valid;
    assign busy        = (state != IDLE);
    assign scan_enable = (state == SHIFT);
    assign scan_in     = scan_enable && shreg[SHIFT_BITS-1];
    assign proc_en     = (state == RUN);

endmodule

// File: tb/tb_scan_bridge.sv
// Self-checking bench for scan_bridge: table of scan transfers, directed
// handshake/run/reset sequences and a randomized mix against a chain-loop model.
module tb_scan_bridge;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       run_req;
    logic       busy;
    logic       timeout;
    logic       scan_enable;
    logic       scan_in;
    logic       proc_en;
    logic       scan_out;
    logic       halt;

    int total = 0;
    int bad   = 0;

    // Core model: an 8-bit scan loop, MSB presented on scan_out.
    logic [7:0] chain;
    logic       chain_load;
    logic [7:0] chain_val;
    logic [7:0] exp_chain;

    assign scan_out = chain[7];

    always @(posedge clk) begin
        if (chain_load) chain <= chain_val;
        else if (scan_enable) chain <= {chain[6:0], scan_in};
    end

    scan_bridge #(.RUN_LIMIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .run_req(run_req), .busy(busy), .timeout(timeout),
        .scan_enable(scan_enable), .scan_in(scan_in), .proc_en(proc_en),
        .scan_out(scan_out), .halt(halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("excl", 32'(scan_enable && proc_en), 0);
        check("sin_outside", 32'(!scan_enable && scan_in), 0);
    endtask

    task automatic start_write(input logic [7:0] d);
        tick();
        check("wr_ready", 32'(wr_ready), 1);
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic finish_shift(input logic [7:0] wr, input logic [7:0] exp_rd, input int hold);
        logic [7:0] bits;
        int n;
        bits = '0;
        n    = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rd_valid) break;
            check("sh_en", 32'(scan_enable), 1);
            check("sh_run", 32'(proc_en), 0);
            check("sh_wrrdy", 32'(wr_ready), 0);
            bits = {bits[6:0], scan_in};
            n++;
        end
        check("sh_len", n, 8);
        check("rd_valid", 32'(rd_valid), 1);
        check("scan_seq", 32'(bits), 32'(wr));
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(rd_valid), 1);
            check("hold_data", 32'(rd_data), 32'(exp_rd));
            check("hold_wrrdy", 32'(wr_ready), 0);
        end
        rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        tick();
        check("rd_done", 32'(rd_valid), 0);
        check("rd_idle", 32'(busy), 0);
    endtask

    task automatic do_run(input int d, input bit early, output int n);
        tick();
        check("run_idle", 32'(busy), 0);
        run_req = 1'b1;
        halt    = early;
        @(posedge clk);
        #1 run_req = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (!proc_en) break;
            n++;
            check("run_busy", 32'(busy), 1);
            check("run_se", 32'(scan_enable), 0);
            if (n == d) halt = 1'b1;
        end
        if (n < 50) check("run_end_busy", 32'(busy), 0);
        halt = 1'b0;
    endtask

    typedef struct {
        logic [7:0] wr;
        logic [7:0] exp_rd;
        int         hold;
    } vec_t;

    vec_t vecs [6];
    int   n;

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 0};
        vecs[1] = '{8'h5A, 8'hA5, 2};
        vecs[2] = '{8'hFF, 8'h5A, 1};
        vecs[3] = '{8'h00, 8'hFF, 3};
        vecs[4] = '{8'h80, 8'h00, 0};
        vecs[5] = '{8'h01, 8'h80, 5};

        rst_n = 1'b0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        run_req = 1'b0; halt = 1'b0; chain_load = 1'b0; chain_val = '0; chain = '0;

        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_wrrdy", 32'(wr_ready), 0);
        check("rst_rdv", 32'(rd_valid), 0);
        check("rst_rdd", 32'(rd_data), 0);
        check("rst_se", 32'(scan_enable), 0);
        check("rst_pe", 32'(proc_en), 0);
        check("rst_to", 32'(timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_wrrdy", 32'(wr_ready), 1);

        chain_val  = 8'h3C;
        chain_load = 1'b1;
        @(posedge clk);
        #1 chain_load = 1'b0;

        foreach (vecs[i]) begin
            start_write(vecs[i].wr);
            finish_shift(vecs[i].wr, vecs[i].exp_rd, vecs[i].hold);
        end
        exp_chain = vecs[5].wr;

        // Read stalled 20+ cycles with a competing write held the whole time.
        start_write(8'h5C);
        wr_data  = 8'h77;
        wr_valid = 1'b1;
        finish_shift(8'h5C, exp_chain, 20);
        exp_chain = 8'h5C;
        check("wr_after_rd", 32'(wr_ready), 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        finish_shift(8'h77, exp_chain, 0);
        exp_chain = 8'h77;

        // Write and run request together: write wins.
        tick();
        wr_data = 8'h3A; wr_valid = 1'b1; run_req = 1'b1;
        @(posedge clk);
        #1 begin wr_valid = 1'b0; run_req = 1'b0; end
        finish_shift(8'h3A, exp_chain, 1);
        exp_chain = 8'h3A;
        tick();
        check("coinc_no_run", 32'(proc_en), 0);

`ifdef SCAN_BRIDGE_WATCHDOG_EN
        do_run(12, 1'b0, n);
        check("run_long", n, 12);
`else
        do_run(37, 1'b0, n);
        check("run_long", n, 37);
`endif
        do_run(1, 1'b1, n);
        check("run_early_halt", n, 1);

`ifdef SCAN_BRIDGE_WATCHDOG_EN
        do_run(0, 1'b0, n);
        check("wd_len", n, 16);
        check("wd_timeout", 32'(timeout), 1);
        tick(); tick();
        check("wd_sticky", 32'(timeout), 1);
        do_run(3, 1'b0, n);
        check("wd_run2", n, 3);
        check("wd_clear", 32'(timeout), 0);
`else
        do_run(0, 1'b0, n);
        check("nowd_len", n, 50);
        check("nowd_timeout", 32'(timeout), 0);
        halt = 1'b1;
        tick(); tick();
        check("nowd_halt", 32'(proc_en), 0);
        halt = 1'b0;
`endif

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic [7:0] w;
                w = 8'($urandom);
                start_write(w);
                finish_shift(w, exp_chain, int'($urandom_range(0, 4)));
                exp_chain = w;
            end else begin
                int d;
                d = int'($urandom_range(1, 14));
                do_run(d, 1'b0, n);
                check("rand_run", n, d);
            end
        end

        // Reset asserted partway through a shift.
        start_write(8'hC3);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_se", 32'(scan_enable), 0);
        check("mid_rst_sin", 32'(scan_in), 0);
        check("mid_rst_pe", 32'(proc_en), 0);
        check("mid_rst_rdv", 32'(rd_valid), 0);
        check("mid_rst_rdd", 32'(rd_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_wrrdy", 32'(wr_ready), 0);
        check("mid_rst_to", 32'(timeout), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("rel_rdv", 32'(rd_valid), 0);
            check("rel_wrrdy", 32'(wr_ready), 1);
            check("rel_busy", 32'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_bridge.md
SCAN_BRIDGE -- requirements
Module: scan_bridge

Interface
REQ-001 SHALL have parameter RUN_LIMIT, default 4096, the maximum processor-run cycles when the watchdog is compiled in.
REQ-002 SHALL have the port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-004 SHALL have the port wr_data, input, 8 bits, the byte to shift into the scan chain.
REQ-005 SHALL have the port wr_valid / wr_ready, input / output, 1 bit each, the write handshake.
REQ-006 SHALL have the port rd_data, output, 8 bits, the byte captured from the chain.
REQ-007 SHALL have the port rd_valid / rd_ready, output / input, 1 bit each, the read handshake.
REQ-008 SHALL have the port run_req, input, 1 bit, a request to run the processor until halt.
REQ-009 SHALL have the port busy, output, 1 bit, high in any state other than IDLE.
REQ-010 SHALL have the port timeout, output, 1 bit, a sticky flag set when a run is aborted.
REQ-011 SHALL have the ports scan_enable, scan_in and proc_en, outputs, 1 bit each, driving the core.
REQ-012 SHALL have the ports scan_out and halt, inputs, 1 bit each, from the core.

Function
REQ-013 SHALL have the states IDLE, SHIFT, HOLD and RUN, encoded as 2 bits.
REQ-014 IDLE: wr_ready = 1 only in IDLE and only when rd_valid = 0.
REQ-015 IDLE: a write transfer (wr_valid && wr_ready) at edge T loads the shift register and goes to SHIFT.
REQ-016 IDLE: run_req in IDLE with no write transfer goes to RUN; if a write and run_req coincide, the write wins and run_req is ignored (not queued).
REQ-017 SHIFT: lasts exactly 8 cycles, with scan_enable = 1 for all 8.
REQ-018 SHIFT: scan_in = the shift-register MSB, so bit 7 is sent first.
REQ-019 SHIFT: each edge shifts left and inserts scan_out at bit 0.
REQ-020 SHIFT: a 3-bit counter wraps 7->0 on exit to HOLD.
REQ-021 HOLD: rd_data = the captured byte and rd_valid = 1 from cycle T+9.
REQ-022 HOLD: rd_data SHALL stay stable until a read transfer (rd_valid && rd_ready), which returns the block to IDLE.
REQ-023 HOLD: an IDLE-state write is blocked while a read is pending.
REQ-024 RUN: proc_en = 1 and scan_enable = 0.
REQ-025 RUN: halt = 1 sampled at an edge returns to IDLE, with proc_en low the next cycle.
REQ-026 RUN: halt already high on entry ends the run after 1 cycle.
REQ-027 scan_enable and proc_en SHALL never both be 1, in any state.
REQ-028 scan_in SHALL be 0 outside SHIFT.
REQ-029 wr_valid and run_req SHALL be ignored outside IDLE, and a held request does not retrigger until the block is back in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, shift register 0, counters 0 and timeout 0.
REQ-031 rst_n low SHALL immediately force the outputs scan_enable = 0, scan_in = 0, proc_en = 0, rd_valid = 0, rd_data = 0 and busy = 0; wr_ready rises once rst_n is high.
REQ-032 Reset mid-SHIFT or mid-RUN SHALL abort with no partial byte reported.
REQ-033 Reset SHALL be released synchronously by the surrounding logic; the block itself adds no synchroniser.

Configuration
REQ-034 Macro SCAN_BRIDGE_WATCHDOG_EN, when defined, SHALL add a run counter of width $clog2(RUN_LIMIT+1), cleared on RUN entry.
REQ-035 With SCAN_BRIDGE_WATCHDOG_EN, reaching RUN_LIMIT cycles without halt SHALL return the block to IDLE and set timeout = 1.
REQ-036 With SCAN_BRIDGE_WATCHDOG_EN, timeout SHALL clear only on reset or on the next accepted run_req.
REQ-037 Without SCAN_BRIDGE_WATCHDOG_EN, RUN SHALL end only on halt, timeout SHALL be tied 0, and no counter SHALL exist.

Structure
REQ-038 Package scan_bridge_pkg SHALL hold the state enum typedef, the SHIFT_BITS = 8 constant and the default RUN_LIMIT.
REQ-039 The block SHALL be a single module with no sub-modules; the shift/capture register is inline.

Verification
REQ-040 Directed scenario: write 0xA5 with a chain model (8-bit loop) preloaded 0x3C -> scan_in sequence 1,0,1,0,0,1,0,1; rd_data = 0x3C and rd_valid at T+9.
REQ-041 Directed scenario: rd_ready held 0 for 20 cycles, then a write attempted -> wr_ready = 0 throughout and rd_data stable; after the read, the write is accepted next cycle.
REQ-042 Directed scenario: run_req with halt rising 37 cycles later -> proc_en high exactly 37 cycles then low, busy falls with it, and scan_enable = 0 all along.
REQ-043 Directed scenario: wr_valid and run_req in the same IDLE cycle -> SHIFT is entered and proc_en never asserts.
REQ-044 Directed scenario: with SCAN_BRIDGE_WATCHDOG_EN and RUN_LIMIT = 16, halt tied 0 -> proc_en high 16 cycles, then timeout = 1 and IDLE; the next run_req clears timeout.
REQ-045 Directed scenario: rst_n pulsed low at SHIFT bit 4 -> all outputs go to reset values asynchronously; rd_valid never asserts and wr_ready = 1 after release.
